// File: rtl/top_mult.sv
// Sequential 8x8 unsigned shift-add multiplier with start/done handshake,
// plus a free-running one-hot digit scanner for an 8-digit display.
module top_mult #(
  parameter int SCAN_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] d_out,
  output logic        done_flag,
  output logic [7:0]  seg_position
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int            PW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);

  state_t        state;
  logic [15:0]   acc;
  logic [15:0]   mcand;
  logic [7:0]    mplier;
  logic [2:0]    cnt;
  logic [PW-1:0] pre;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      d_out     <= '0;
      done_flag <= 1'b0;
    end else begin
      done_flag <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {8'h00, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            state  <= CALC;
          end
        end
        CALC: begin
          // product of two 8-bit values fits in 16 bits, so acc never overflows
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= {mcand[14:0], 1'b0};
          mplier <= {1'b0, mplier[7:1]};
          cnt    <= cnt + 3'd1;
          if (cnt == 3'd7) state <= DONE;
        end
        DONE: begin
          d_out     <= acc;
          done_flag <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // scanner is independent of the multiplier FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre          <= '0;
      seg_position <= 8'b0000_0001;
    end else if (pre == PMAX) begin
      pre          <= '0;
      seg_position <= {seg_position[6:0], seg_position[7]};
    end else begin
      pre <= pre + 1'b1;
    end
  end

endmodule

// File: tb/tb_top_mult.sv
// Randomized and directed bench for top_mult; a transaction-level model
// predicts product, done pulse and scanner position every cycle.
module tb_top_mult;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  a, b;
  logic [15:0] d_out, d_out4;
  logic        done_flag, done_flag4;
  logic [7:0]  seg_position, seg_position4;

  int n_chk  = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  top_mult #(.SCAN_DIV(1)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .d_out(d_out), .done_flag(done_flag), .seg_position(seg_position));

  top_mult #(.SCAN_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .d_out(d_out4), .done_flag(done_flag4), .seg_position(seg_position4));

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a multiply is "in flight" for 9 edges after its load; the product
  // appears on the 9th. Scanner position is a pure function of cycle count.
  int          left;
  logic [15:0] pend;
  logic [15:0] m_d;
  logic        m_done;
  int          k;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      left   <= 0;
      pend   <= '0;
      m_d    <= '0;
      m_done <= 1'b0;
      k      <= 0;
    end else begin
      k      <= k + 1;
      m_done <= 1'b0;
      if (left > 0) begin
        left <= left - 1;
        if (left == 1) begin
          m_d    <= pend;
          m_done <= 1'b1;
        end
      end else if (start === 1'b1) begin
        pend <= 16'(a) * 16'(b);
        left <= 9;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("d_out", d_out, m_d);
      chk("done_flag", {15'd0, done_flag}, {15'd0, m_done});
      chk("seg1", {8'd0, seg_position}, {8'd0, 8'(1 << (k % 8))});
      chk("d_out4", d_out4, m_d);
      chk("done_flag4", {15'd0, done_flag4}, {15'd0, m_done});
      chk("seg4", {8'd0, seg_position4}, {8'd0, 8'(1 << ((k / 4) % 8))});
    end
  end

  // waits up to max_cyc negedges for done_flag; returns cycles taken (0 on timeout)
  task automatic wait_done(input int max_cyc, output int cyc);
    cyc = 0;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk);
      if (done_flag === 1'b1) begin
        cyc = i;
        break;
      end
    end
    if (cyc == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_done: no done_flag within %0d cycles", max_cyc);
    end
  endtask

  logic [7:0]  pa [6];
  logic [7:0]  pb [6];
  logic [15:0] pp [6];
  logic [7:0]  seq1 [9];
  logic [7:0]  seq4 [9];

  initial begin
    int cyc, last, first, npulse, ndone;
    pa = '{8'hF0, 8'h0F, 8'hFF, 8'hFF, 8'hAB, 8'h11};
    pb = '{8'h35, 8'h44, 8'h00, 8'hF1, 8'hCD, 8'h11};
    pp = '{16'h31B0, 16'h03FC, 16'h0000, 16'hF00F, 16'h88EF, 16'h0121};
    seq1 = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    seq4 = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h02, 8'h02, 8'h02, 8'h02, 8'h04};

    rst = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_d_out", d_out, 16'h0000);
    chk("rst_done", {15'd0, done_flag}, 16'd0);
    chk("rst_seg", {8'd0, seg_position}, 16'h0001);
    chk("rst_seg4", {8'd0, seg_position4}, 16'h0001);
    rst = 1'b1;
    mon_en = 1'b1;

    // scanner sequence directly after reset
    for (int i = 0; i < 9; i++) begin
      chk("scan1", {8'd0, seg_position}, {8'd0, seq1[i]});
      chk("scan4", {8'd0, seg_position4}, {8'd0, seq4[i]});
      @(negedge clk);
    end

    // single operation, latency check
    a = 8'h81; b = 8'h13; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'h00; b = 8'h00;
    wait_done(20, cyc);
    chk("single_lat", 16'(cyc + 1), 16'd10);
    chk("single_d_out", d_out, 16'h0993);
    repeat (3) @(negedge clk);

    // back-to-back with start held high
    start = 1'b1;
    for (int p = 0; p < 6; p++) begin
      a = pa[p]; b = pb[p];
      last = 0; first = 0; npulse = 0;
      for (int i = 1; i <= 20; i++) begin
        @(negedge clk);
        if (done_flag === 1'b1) begin
          if (npulse == 0) first = i;
          last = i;
          npulse++;
        end
      end
      chk("b2b_pulses", 16'(npulse), 16'd2);
      chk("b2b_period", 16'(last - first), 16'd10);
      chk("b2b_prod", d_out, pp[p]);
    end

    // operands changed mid-calculation
    start = 1'b0;
    repeat (12) @(negedge clk);
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'h12; b = 8'h34;
    wait_done(20, cyc);
    chk("midchg_d_out", d_out, 16'hFE01);

    // start withdrawn: output holds, no pulses
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_flag === 1'b1) ndone++;
      a = 8'($urandom); b = 8'($urandom);
    end
    chk("idle_no_done", 16'(ndone), 16'd0);
    chk("idle_hold", d_out, 16'hFE01);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      start = ($urandom_range(0, 3) != 0);
      a = 8'($urandom);
      b = 8'($urandom);
      @(negedge clk);
    end

    // asynchronous reset in the middle of a calculation
    start = 1'b1; a = 8'hC3; b = 8'h5A;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_d_out", d_out, 16'h0000);
    chk("arst_done", {15'd0, done_flag}, 16'd0);
    chk("arst_seg", {8'd0, seg_position}, 16'h0001);
    chk("arst_seg4", {8'd0, seg_position4}, 16'h0001);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done_flag === 1'b1) ndone++;
    end
    chk("arst_no_done", 16'(ndone), 16'd0);
    chk("arst_d_hold", d_out, 16'h0000);

    // first edge after reset acts as IDLE
    a = 8'h07; b = 8'h09; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(20, cyc);
    chk("post_rst_d_out", d_out, 16'h003F);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/top_mult.md
# top_mult

Sequential 8×8 unsigned shift-add multiplier with a start/done handshake and a free-running one-hot display digit scanner. It is the top-level block of the multiplier demo. It accepts operands `a` and `b` on `start` and produces a 16-bit product after a fixed latency. `seg_position` drives the digit-select lines of an external 8-digit seven-segment display that shows `d_out`.

## Interface
Parameters:
- `SCAN_DIV`, default 1: clock cycles per `seg_position` rotation step; legal range ≥ 1.

Ports:
- `clk`, input, 1: single system clock, rising-edge.
- `rst`, input, 1: reset; asynchronous, active-low.
- `start`, input, 1: level-sensitive request; sampled only in IDLE.
- `a`, input, 8: multiplicand, unsigned.
- `b`, input, 8: multiplier, unsigned.
- `d_out`, output, 16: product register; holds the last result.
- `done_flag`, output, 1: one-cycle pulse when `d_out` updates.
- `seg_position`, output, 8: one-hot, active-high digit select.

## Operation
- FSM states: IDLE, CALC, DONE. All state and outputs are registered.
- IDLE:
  - If `start`==1 at the clock edge: load `mcand`={8'h00,`a`}, `mplier`=`b`, `acc`=0, `cnt`=0, then go to CALC.
  - Otherwise stay in IDLE.
  - `start`==0 or X/Z keeps the FSM in IDLE.
- CALC, one iteration per cycle:
  - If `mplier[0]`, then `acc`=`acc`+`mcand` (16-bit, no overflow possible).
  - `mcand`<<=1, `mplier`>>=1, `cnt`++.
  - After the 8th iteration (`cnt`==7 at the edge), go to DONE.
- DONE: `d_out`<=`acc`, `done_flag`<=1, go to IDLE.
- In every other state `done_flag`<=0.
- `a`/`b` are sampled only at load. Changes during CALC/DONE do not affect the running product.
- `start` held high gives back-to-back multiplications. Each new load samples the current `a`/`b`.
- `start` dropping during CALC does not abort the operation; it always completes.
- `d_out` is unchanged except in DONE. It retains its value between operations.
- Scanner:
  - Prescale counter counts 0..`SCAN_DIV`-1.
  - On wrap, `seg_position` rotates left one bit (bit7→bit0).
  - The scanner runs independently of the FSM and of `start`.
- Reset (`rst`==0, asynchronous, any state including mid-CALC):
  - State=IDLE, `acc`/`mcand`/`mplier`/`cnt`=0.
  - `d_out`=16'h0000, `done_flag`=0, `seg_position`=8'b0000_0001, prescaler=0.
  - After `rst` returns high, the first edge behaves as in IDLE.

## Timing
- Start sampled at edge N gives:
  - 8 CALC edges N+1..N+8.
  - `d_out` valid and `done_flag`=1 after edge N+9.
  - `done_flag` returns to 0 after edge N+10.
- Latency from start sampled to result: 9 cycles.
- Throughput with `start` held high: one result every 10 cycles. The reload occurs on the same edge that clears `done_flag`.
- Simultaneous `start` with `done_flag` high: start is honored, because the FSM is already in IDLE.
- `seg_position` with `SCAN_DIV`=1: rotates every clock; returns to 8'h01 every 8 cycles.

## Test plan
- Reset: pulse `rst` low mid-operation → immediately `d_out`=0, `done_flag`=0, `seg_position`=8'h01, FSM IDLE; no `done_flag` until a new start.
- Single op: `a`=8'h81, `b`=8'h13, `start` high for one cycle → `done_flag` pulses 9 cycles later, `d_out`=16'h0993.
- Continuous `start`=1 with operands changed every 20 cycles. Required `d_out` per pair:
  - F0×35 = 16'h31B0
  - 0F×44 = 16'h03FC
  - FF×00 = 16'h0000
  - FF×F1 = 16'hF00F
  - AB×CD = 16'h88EF
  - 11×11 = 16'h0121
  - `done_flag` pulses every 10 cycles.
- Operand change mid-CALC: load 8'hFF×8'hFF, change `a`/`b` on cycle 3 → `d_out`=16'hFE01.
- Start withdrawn: `start`=0 after one result → `done_flag` stays 0 and `d_out` holds its value indefinitely.
- Scanner: after reset with `SCAN_DIV`=1 → sequence 01,02,04,…,80,01; with `SCAN_DIV`=4 each value is held 4 cycles.
